// File: rtl/tile_sequencer_if.sv
// Command-buffer write port between tile_sequencer and the gpu_core Avalon slave.
// cmd_ready is the inverse of the slave's wait request.
interface tile_sequencer_if;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (output cmd_addr, output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_addr, input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/tile_sequencer.sv
// Walks a triangle's tile bounding box x-major and streams the per-tile
// edge/address/raster/write command words, closing with a flush wait.
module tile_sequencer #(
  parameter int TILE_SHIFT      = 5,
  parameter int PIX_BYTES_SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [5:0]          tx0,
  input  logic [5:0]          ty0,
  input  logic [5:0]          tx1,
  input  logic [5:0]          ty1,
  input  logic signed [31:0]  w0_base,
  input  logic signed [31:0]  w1_base,
  input  logic signed [31:0]  w2_base,
  input  logic signed [31:0]  w0_dx,
  input  logic signed [31:0]  w1_dx,
  input  logic signed [31:0]  w2_dx,
  input  logic signed [31:0]  w0_dy,
  input  logic signed [31:0]  w1_dy,
  input  logic signed [31:0]  w2_dy,
  input  logic [31:0]         fb_base,
  input  logic [15:0]         stride,
  tile_sequencer_if.master    cmd,
  output logic                busy,
  output logic                done
);

  typedef enum logic [3:0] {
    IDLE, STRIDE, W0, W1, W2, ADDR, RASTER, WRITE, NEXT, FLUSH, DONE
  } state_t;

  state_t st;

  logic [5:0]         r_tx0, r_tx1, r_ty1, tx, ty;
  logic               r_empty;
  logic [15:0]        r_stride;
  logic signed [31:0] dx0, dx1, dx2, dy0, dy1, dy2;
  logic signed [31:0] cur_w0, cur_w1, cur_w2, row_w0, row_w1, row_w2;
  logic [31:0]        cur_addr, row_addr;

  logic               fire, row_end, last_tile;
  logic [31:0]        stride_row, tile_bytes;
  logic signed [31:0] nxt_w0, nxt_w1, nxt_w2, nxt_row_w0, nxt_row_w1, nxt_row_w2;
  logic [31:0]        nxt_addr, nxt_row_addr;

  // Running values for the tile after the current one; at a row end both the
  // row origin and the current tile move down by one tile row.
  always_comb begin
    fire         = cmd.cmd_valid & cmd.cmd_ready;
    row_end      = (tx == r_tx1);
    last_tile    = row_end && (ty == r_ty1);
    stride_row   = {16'b0, r_stride} << TILE_SHIFT;
    tile_bytes   = 32'd1 << (TILE_SHIFT + PIX_BYTES_SHIFT);
    nxt_row_w0   = row_end ? row_w0 + dy0 : row_w0;
    nxt_row_w1   = row_end ? row_w1 + dy1 : row_w1;
    nxt_row_w2   = row_end ? row_w2 + dy2 : row_w2;
    nxt_row_addr = row_end ? row_addr + stride_row : row_addr;
    nxt_w0       = row_end ? nxt_row_w0 : cur_w0 + dx0;
    nxt_w1       = row_end ? nxt_row_w1 : cur_w1 + dx1;
    nxt_w2       = row_end ? nxt_row_w2 : cur_w2 + dx2;
    nxt_addr     = row_end ? nxt_row_addr : cur_addr + tile_bytes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st                                            <= IDLE;
      {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data}   <= '0;
      busy                                          <= 1'b0;
      done                                          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          r_tx0    <= tx0;
          r_tx1    <= tx1;
          r_ty1    <= ty1;
          tx       <= tx0;
          ty       <= ty0;
          r_empty  <= (tx1 < tx0) || (ty1 < ty0);
          r_stride <= stride;
          dx0 <= w0_dx;  dx1 <= w1_dx;  dx2 <= w2_dx;
          dy0 <= w0_dy;  dy1 <= w1_dy;  dy2 <= w2_dy;
          cur_w0 <= w0_base;  cur_w1 <= w1_base;  cur_w2 <= w2_base;
          row_w0 <= w0_base;  row_w1 <= w1_base;  row_w2 <= w2_base;
          cur_addr <= fb_base;
          row_addr <= fb_base;
          busy     <= 1'b1;
          st       <= STRIDE;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd9, 16'b0, stride};
        end
        STRIDE: if (fire) begin
          if (r_empty) begin
            st <= FLUSH;
            {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd0, 32'd4};
          end else begin
            st <= W0;
            {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd5, cur_w0};
          end
        end
        W0: if (fire) begin
          st <= W1;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd6, cur_w1};
        end
        W1: if (fire) begin
          st <= W2;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd7, cur_w2};
        end
        W2: if (fire) begin
          st <= ADDR;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd8, cur_addr};
        end
        ADDR: if (fire) begin
          st <= RASTER;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd0, 32'd0};
        end
        RASTER: if (fire) begin
          st <= WRITE;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd0, 32'd2};
        end
        WRITE: if (fire) begin
          st <= NEXT;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= '0;
        end
        // Equality end tests keep tx1/ty1 = 63 from wrapping the 6-bit counters.
        NEXT: begin
          if (last_tile) begin
            st <= FLUSH;
            {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd0, 32'd4};
          end else begin
            tx       <= row_end ? r_tx0 : tx + 6'd1;
            ty       <= row_end ? ty + 6'd1 : ty;
            cur_w0   <= nxt_w0;  cur_w1 <= nxt_w1;  cur_w2 <= nxt_w2;
            row_w0   <= nxt_row_w0;  row_w1 <= nxt_row_w1;  row_w2 <= nxt_row_w2;
            cur_addr <= nxt_addr;
            row_addr <= nxt_row_addr;
            st       <= W0;
            {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= {1'b1, 4'd5, nxt_w0};
          end
        end
        FLUSH: if (fire) begin
          st   <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
          {cmd.cmd_valid, cmd.cmd_addr, cmd.cmd_data} <= '0;
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
